tsc_fifo_v2_ctrl: RTL and testbench



---
 rtl/tsc_fifo_pkg.sv | 7 +
 rtl/tsc_fifo_v2_ctrl_if.sv | 13 +
 rtl/tsc_fifo_v2_obuf.sv | 37 +++
 rtl/tsc_fifo_v2_ctrl.sv | 65 ++++++
 tb/tb_tsc_fifo_v2_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/tsc_fifo_pkg.sv
// tsc_fifo_pkg: shared sizing defaults for the MIPI-to-video FIFO controller
package tsc_fifo_pkg;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;
  localparam int AFULL_TH = 1000;
endpackage

// File: rtl/tsc_fifo_v2_ctrl_if.sv
// tsc_fifo_v2_ctrl_if: write and first-word-fall-through read handshakes of the FIFO
interface tsc_fifo_v2_ctrl_if import tsc_fifo_pkg::*; #(
  parameter int W = DW
);
  logic wr_valid;
  logic wr_ready;
  logic [W-1:0] wr_data;
  logic rd_valid;
  logic rd_ready;
  logic [W-1:0] rd_data;
  modport master (output wr_valid, wr_data, rd_ready, input wr_ready, rd_valid, rd_data);
  modport slave (input wr_valid, wr_data, rd_ready, output wr_ready, rd_valid, rd_data);
endinterface

// File: rtl/tsc_fifo_v2_obuf.sv
// tsc_fifo_v2_obuf: 2-entry in-order output buffer that absorbs RAM read latency
module tsc_fifo_v2_obuf import tsc_fifo_pkg::*; #(
  parameter int W = DW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   cnt
);
  logic [W-1:0] e0, e1, e0_n, e1_n;
  logic [1:0] cnt_n;
  logic do_pop;
  assign do_pop = pop & (cnt != 2'd0);
  assign dout = e0;
  // e0 is always the head; e1 only holds a word while e0 is occupied
  always_comb begin
    e0_n = (push & ((cnt == 2'd0) | (do_pop & (cnt == 2'd1)))) ? din :
           (do_pop & (cnt == 2'd2)) ? e1 : e0;
    e1_n = (push & (((cnt == 2'd1) & ~do_pop) | ((cnt == 2'd2) & do_pop))) ? din : e1;
    cnt_n = flush ? 2'd0 : cnt + {1'b0, push} - {1'b0, do_pop};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0 <= '0;
      e1 <= '0;
      cnt <= 2'd0;
    end else begin
      e0 <= e0_n;
      e1 <= e1_n;
      cnt <= cnt_n;
    end
  end
endmodule

// File: rtl/tsc_fifo_v2_ctrl.sv
// tsc_fifo_v2_ctrl: pointer/occupancy control for a 1-cycle-latency SDP RAM with
// a FWFT read side; capacity is the RAM depth plus the 2-entry output buffer.
module tsc_fifo_v2_ctrl import tsc_fifo_pkg::*; #(
  parameter int AW = tsc_fifo_pkg::AW,
  parameter int DW = tsc_fifo_pkg::DW,
  parameter int AFULL_TH = tsc_fifo_pkg::AFULL_TH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  tsc_fifo_v2_ctrl_if.slave   bus,
  output logic [AW:0]         level,
  output logic                almost_full,
  output logic [AW-1:0]       ram_aw,
  output logic                ram_cew,
  output logic [DW-1:0]       ram_dw,
  output logic [AW-1:0]       ram_ar,
  output logic                ram_cer,
  input  logic [DW-1:0]       ram_qr
);
  localparam logic [AW:0] AF_TH = (AW+1)'(AFULL_TH);
  logic [AW:0] wp, rp, ram_cnt, level_n;
  logic [1:0] out_cnt;
  logic [2:0] occ;
  logic inflight, acc, pop;
  assign ram_cnt = wp - rp;
  // ram_cnt only reaches 2^AW when the RAM is full, so its MSB is the full flag
  assign bus.wr_ready = ~rst & ~flush & ~ram_cnt[AW];
  assign acc = bus.wr_valid & bus.wr_ready;
  assign pop = bus.rd_valid & bus.rd_ready;
  assign occ = {1'b0, out_cnt} + {2'b0, inflight} - {2'b0, pop};
  assign ram_cer = ~rst & ~flush & (ram_cnt != '0) & (occ < 3'd2);
  assign ram_cew = acc;
  assign ram_aw = wp[AW-1:0];
  assign ram_dw = bus.wr_data;
  assign ram_ar = rp[AW-1:0];
  assign bus.rd_valid = out_cnt != 2'd0;
  assign level_n = flush ? '0 : level + {{AW{1'b0}}, acc} - {{AW{1'b0}}, pop};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      inflight <= 1'b0;
      level <= '0;
      almost_full <= 1'b0;
    end else begin
      wp <= flush ? '0 : wp + {{AW{1'b0}}, acc};
      rp <= flush ? '0 : rp + {{AW{1'b0}}, ram_cer};
      inflight <= ram_cer;
      level <= level_n;
      almost_full <= level_n >= AF_TH;
    end
  end
  // read data returning during a flush cycle belongs to discarded contents
  tsc_fifo_v2_obuf #(.W(DW)) u_obuf (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .push (inflight & ~flush),
    .pop  (pop),
    .din  (ram_qr),
    .dout (bus.rd_data),
    .cnt  (out_cnt)
  );
endmodule

// File: tb/tb_tsc_fifo_v2_ctrl.sv
// tb_tsc_fifo_v2_ctrl: randomized and directed checks of the FIFO controller against a queue model
module tb_tsc_fifo_v2_ctrl;
  import tsc_fifo_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;
  tsc_fifo_v2_ctrl_if bus();
  logic [AW:0] level;
  logic almost_full, ram_cew, ram_cer;
  logic [AW-1:0] ram_aw, ram_ar;
  logic [DW-1:0] ram_dw, ram_qr;
  tsc_fifo_v2_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .level(level), .almost_full(almost_full),
    .ram_aw(ram_aw), .ram_cew(ram_cew), .ram_dw(ram_dw),
    .ram_ar(ram_ar), .ram_cer(ram_cer), .ram_qr(ram_qr)
  );
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_cew) mem[ram_aw] <= ram_dw;
    if (ram_cer) ram_qr <= mem[ram_ar];
  end
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] q[$];
  bit acc, popd;
  logic [DW-1:0] pop_data, exp_data;
  // one clock of the reference model: handshakes seen at negedge, queue updated, returns at posedge+1
  task automatic step();
    @(negedge clk);
    acc = bus.wr_valid & bus.wr_ready;
    popd = bus.rd_valid & bus.rd_ready;
    pop_data = bus.rd_data;
    exp_data = (popd && q.size() > 0) ? q[0] : 'x;
    if (flush) q.delete();
    else begin
      if (popd && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(bus.wr_data);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    bus.wr_valid = 1'b1; bus.wr_data = 32'h1234_5678; bus.rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL rst_wr_ready got=%0h exp=0", bus.wr_ready); end
    checks++; if (ram_cew !== 1'b0) begin failures++; $display("FAIL rst_ram_cew got=%0h exp=0", ram_cew); end
    bus.wr_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%0h exp=0", bus.rd_valid); end
    checks++; if (bus.rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%0h exp=0", bus.rd_data); end
    checks++; if (level !== '0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_almost_full got=%0h exp=0", almost_full); end
    checks++; if (ram_cer !== 1'b0) begin failures++; $display("FAIL reset_ram_cer got=%0h exp=0", ram_cer); end
    checks++; if (ram_aw !== '0 || ram_ar !== '0) begin failures++; $display("FAIL reset_ram_addr got=%0h/%0h exp=0/0", ram_aw, ram_ar); end
    checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%0h exp=1", bus.wr_ready); end
  endtask
  task automatic test_latency();
    bus.wr_valid = 1'b1; bus.wr_data = 32'hDEAD_BEEF; bus.rd_ready = 1'b0;
    step();
    bus.wr_valid = 1'b0;
    checks++; if (ram_cer !== 1'b1) begin failures++; $display("FAIL lat_ram_cer_c1 got=%0h exp=1", ram_cer); end
    checks++; if (level !== 11'd1) begin failures++; $display("FAIL lat_level got=%0d exp=1", level); end
    step();
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL lat_rd_valid_c2 got=%0h exp=0", bus.rd_valid); end
    step();
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lat_c3 got=%0h/%0h exp=1/deadbeef", bus.rd_valid, bus.rd_data); end
    bus.rd_ready = 1'b1;
    step();
    bus.rd_ready = 1'b0;
    checks++; if (!popd || pop_data !== exp_data) begin failures++; $display("FAIL lat_pop got=%0h exp=%0h", pop_data, exp_data); end
    checks++; if (level !== '0) begin failures++; $display("FAIL lat_level_after got=%0d exp=0", level); end
  endtask
  task automatic test_fill();
    int n = 0;
    bus.wr_valid = 1'b1; bus.rd_ready = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      bus.wr_data = $urandom;
      step();
      if (acc) n++;
      if (acc && n == 999) begin checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL fill_af_999 got=%0h exp=0", almost_full); end end
      if (acc && n == 1000) begin checks++; if (almost_full !== 1'b1) begin failures++; $display("FAIL fill_af_1000 got=%0h exp=1", almost_full); end end
    end
    checks++; if (n != 1026) begin failures++; $display("FAIL fill_count got=%0d exp=1026", n); end
    checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL fill_wr_ready got=%0h exp=0", bus.wr_ready); end
    checks++; if (level !== 11'd1026) begin failures++; $display("FAIL fill_level got=%0d exp=1026", level); end
    bus.wr_valid = 1'b0;
  endtask
  task automatic test_full_pop();
    bus.wr_valid = 1'b0; bus.rd_ready = 1'b1;
    #1;
    checks++; if (ram_cer !== 1'b1) begin failures++; $display("FAIL full_pop_ram_cer got=%0h exp=1", ram_cer); end
    step();
    bus.rd_ready = 1'b0;
    checks++; if (!popd || pop_data !== exp_data) begin failures++; $display("FAIL full_pop_data got=%0h exp=%0h", pop_data, exp_data); end
    checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL full_pop_wr_ready got=%0h exp=1", bus.wr_ready); end
    bus.wr_valid = 1'b1; bus.wr_data = $urandom;
    step();
    bus.wr_valid = 1'b0;
    checks++; if (!acc || level !== 11'd1026) begin failures++; $display("FAIL full_refill got=%0h/%0d exp=1/1026", acc, level); end
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 1100 && q.size() > 0; i++) begin
      step();
      if (popd) begin checks++; if (pop_data !== exp_data) begin failures++; $display("FAIL drain_data got=%0h exp=%0h", pop_data, exp_data); end end
    end
    bus.rd_ready = 1'b0;
    checks++; if (level !== '0 || bus.rd_valid !== 1'b0 || q.size() != 0) begin failures++; $display("FAIL drain_empty got=%0d/%0h/%0d exp=0/0/0", level, bus.rd_valid, q.size()); end
  endtask
  task automatic test_stream();
    int written = 0, popped = 0, first = -1, bubbles = 0, stalls = 0;
    bus.wr_valid = 1'b1; bus.rd_ready = 1'b1;
    for (int c = 0; c < 6000 && popped < 5000; c++) begin
      bus.wr_data = written;
      step();
      if (bus.wr_valid && !acc) stalls++;
      if (acc) written++;
      if (written == 5000) bus.wr_valid = 1'b0;
      if (popd) begin
        if (first < 0) first = c;
        popped++;
        checks++; if (pop_data !== exp_data) begin failures++; $display("FAIL stream_data got=%0h exp=%0h", pop_data, exp_data); end
      end else if (first >= 0) bubbles++;
    end
    bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
    checks++; if (first != 3) begin failures++; $display("FAIL stream_first got=%0d exp=3", first); end
    checks++; if (popped != 5000 || bubbles != 0 || stalls != 0) begin failures++; $display("FAIL stream_flow got=%0d/%0d/%0d exp=5000/0/0", popped, bubbles, stalls); end
  endtask
  task automatic test_flush();
    bus.wr_valid = 1'b1; bus.rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin bus.wr_data = 32'hF000 + i; step(); end
    bus.wr_valid = 1'b0;
    repeat (4) step();
    bus.wr_valid = 1'b1; bus.wr_data = 32'hF005; bus.rd_ready = 1'b1;
    step();
    flush = 1'b1; bus.wr_data = 32'hBAD0;
    #1;
    checks++; if (bus.wr_ready !== 1'b0 || ram_cer !== 1'b0) begin failures++; $display("FAIL flush_gate got=%0h/%0h exp=0/0", bus.wr_ready, ram_cer); end
    step();
    flush = 1'b0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
    checks++; if (bus.rd_valid !== 1'b0 || level !== '0) begin failures++; $display("FAIL flush_clear got=%0h/%0d exp=0/0", bus.rd_valid, level); end
    step();
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL flush_stale got=%0h exp=0", bus.rd_valid); end
    bus.wr_valid = 1'b1; bus.wr_data = 32'h1;
    step();
    bus.wr_valid = 1'b0;
    step(); step();
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h1) begin failures++; $display("FAIL flush_after got=%0h/%0h exp=1/1", bus.rd_valid, bus.rd_data); end
    bus.rd_ready = 1'b1;
    step();
    bus.rd_ready = 1'b0;
  endtask
  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      bus.wr_valid = (c < 2000) ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 3);
      bus.rd_ready = (c < 2000) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 9);
      bus.wr_data = $urandom;
      flush = ($urandom_range(0, 999) == 0);
      step();
      if (popd) begin checks++; if (pop_data !== exp_data) begin failures++; $display("FAIL rand_data got=%0h exp=%0h", pop_data, exp_data); end end
      checks++; if (level !== (AW+1)'(q.size())) begin failures++; $display("FAIL rand_level got=%0d exp=%0d", level, q.size()); end
      checks++; if (almost_full !== (q.size() >= AFULL_TH)) begin failures++; $display("FAIL rand_af got=%0h exp=%0h", almost_full, q.size() >= AFULL_TH); end
    end
    flush = 1'b0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
  endtask
  task automatic test_async_reset();
    bus.wr_valid = 1'b1; bus.rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin bus.wr_data = $urandom; step(); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== '0 || level !== '0 || almost_full !== 1'b0) begin failures++; $display("FAIL arst_out got=%0h/%0h/%0d/%0h exp=0/0/0/0", bus.rd_valid, bus.rd_data, level, almost_full); end
    checks++; if (ram_cer !== 1'b0 || ram_cew !== 1'b0 || bus.wr_ready !== 1'b0) begin failures++; $display("FAIL arst_ram got=%0h/%0h/%0h exp=0/0/0", ram_cer, ram_cew, bus.wr_ready); end
    q.delete();
    bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_data = 32'hA5A5_0001;
    step();
    bus.wr_valid = 1'b0;
    step(); step();
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'hA5A5_0001 || level !== 11'd1) begin failures++; $display("FAIL arst_recover got=%0h/%0h/%0d exp=1/a5a50001/1", bus.rd_valid, bus.rd_data, level); end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_latency();
    test_fill();
    test_full_pop();
    test_stream();
    test_flush();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
